// File: rtl/decoder_2to4_seq_if.sv
// Request/response bundle for the sequenced 2-to-4 decoder.
// The master drives the code and enable; the slave returns the handshake and one-hot lines.
interface decoder_2to4_seq_if;
   logic       en;
   logic       in_valid;
   logic [1:0] A;
   logic       in_ready;
   logic [3:0] Y;
   logic       busy;
   logic       done;

   modport master (
      output en, in_valid, A,
      input  in_ready, Y, busy, done
   );

   modport slave (
      input  en, in_valid, A,
      output in_ready, Y, busy, done
   );
endinterface

// File: rtl/decoder_2to4_seq.sv
// Registered 2-to-4 decoder with a valid/ready intake.
// Holds the one-hot line for HOLD_CYCLES cycles, then idles GAP_CYCLES cycles before the next accept.
module decoder_2to4_seq #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 1,
   parameter int unsigned CW          = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   decoder_2to4_seq_if.slave bus_io
);

   typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

   localparam logic [CW-1:0] HoldLoad = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GapLoad  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    y_q;
   logic          done_q;
   logic          accept;

   assign bus_io.in_ready = (state_q == StIdle) & bus_io.en & rst_n;
   assign accept          = bus_io.in_valid & bus_io.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         y_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               y_q <= '0;
               if (accept) begin
                  y_q     <= 4'b0001 << bus_io.A;
                  cnt_q   <= HoldLoad;
                  state_q <= StHold;
               end
            end
            StHold: begin
               // Dropping en aborts the hold and wins over a normal completion on the same edge.
               if (!bus_io.en || (cnt_q == '0)) begin
                  y_q    <= '0;
                  done_q <= bus_io.en;
                  if (GAP_CYCLES > 0) begin
                     cnt_q   <= GapLoad;
                     state_q <= StGap;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            StGap: begin
               y_q <= '0;
               if (cnt_q == '0) begin
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: begin
               y_q     <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus_io.Y    = y_q;
   assign bus_io.done = done_q;
   assign bus_io.busy = (state_q != StIdle);

endmodule

// File: tb/tb_decoder_2to4_seq.sv
// Bench for decoder_2to4_seq: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0) checked
// cycle by cycle against a queue of expected output states pushed at each predicted accept.
module tb_decoder_2to4_seq;

   localparam int unsigned HoldA = 4;
   localparam int unsigned GapA  = 1;
   localparam int unsigned HoldB = 1;
   localparam int unsigned GapB  = 0;

   typedef struct packed {
      logic [3:0] y;
      logic       done;
      logic       busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   decoder_2to4_seq_if ifa ();
   decoder_2to4_seq_if ifb ();

   decoder_2to4_seq #(.HOLD_CYCLES(HoldA), .GAP_CYCLES(GapA), .CW(8)) u_dut_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (ifa)
   );

   decoder_2to4_seq #(.HOLD_CYCLES(HoldB), .GAP_CYCLES(GapB), .CW(8)) u_dut_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (ifb)
   );

   always #5 clk = ~clk;

   // Expected state for the cycle now being observed; idle when nothing is queued.
   task automatic pop(input bit sel, output exp_t e);
      @(negedge clk);
      e = '0;
      if (sel) begin
         if (q_b.size() > 0) e = q_b.pop_front();
      end else if (q_a.size() > 0) begin
         e = q_a.pop_front();
      end
   endtask

   task automatic push(input bit sel, input exp_t e);
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
   endtask

   // Apply inputs for the next edge and extend the expected trace accordingly.
   task automatic drive(input bit sel, input exp_t cur, input logic v, input logic en,
                        input logic [1:0] a, output bit acc);
      int unsigned hold;
      int unsigned gap;
      hold = sel ? HoldB : HoldA;
      gap  = sel ? GapB : GapA;
      if (sel) begin
         ifb.in_valid = v; ifb.en = en; ifb.A = a;
      end else begin
         ifa.in_valid = v; ifa.en = en; ifa.A = a;
      end
      acc = v && en && !cur.busy;
      if (acc) begin
         for (int i = 0; i < int'(hold); i++) push(sel, {4'b0001 << a, 1'b0, 1'b1});
         push(sel, {4'b0000, 1'b1, gap > 0});
         for (int i = 1; i < int'(gap); i++) push(sel, {4'b0000, 1'b0, 1'b1});
      end else if (!en && cur.y != 4'b0000) begin
         if (sel) q_b.delete();
         else     q_a.delete();
         for (int i = 0; i < int'(gap); i++) push(sel, {4'b0000, 1'b0, 1'b1});
      end
   endtask

   task automatic test_reset();
      exp_t e;
      bit   acc;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++;
         if ({ifa.Y, ifa.done, ifa.busy, ifa.in_ready} !== 7'b0000_000) begin
            n_fail++;
            $display("FAIL reset c%0d: Y/done/busy/rdy=%b/%b/%b/%b want 0000/0/0/0",
                     c, ifa.Y, ifa.done, ifa.busy, ifa.in_ready);
         end
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (ifa.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: in_ready=%b want 1", ifa.in_ready);
      end
      drive(0, '0, 1'b1, 1'b1, 2'b10, acc);
      for (int c = 0; c < 8; c++) begin
         pop(0, e);
         n_checks++;
         if ({ifa.Y, ifa.done, ifa.busy, ifa.in_ready} !== {e.y, e.done, e.busy, ifa.en & ~e.busy}) begin
            n_fail++;
            $display("FAIL reset_first c%0d: Y/done/busy/rdy=%b/%b/%b/%b want %b/%b/%b/%b", c,
                     ifa.Y, ifa.done, ifa.busy, ifa.in_ready, e.y, e.done, e.busy, ifa.en & ~e.busy);
         end
         drive(0, e, 1'b0, 1'b1, 2'b00, acc);
      end
   endtask

   task automatic test_each_code();
      exp_t e;
      bit   acc;
      int   idx  = 0;
      int   last = -1;
      for (int c = 0; c < 26; c++) begin
         pop(0, e);
         n_checks++;
         if ({ifa.Y, ifa.done, ifa.busy, ifa.in_ready} !== {e.y, e.done, e.busy, ifa.en & ~e.busy}) begin
            n_fail++;
            $display("FAIL each_code c%0d: Y/done/busy/rdy=%b/%b/%b/%b want %b/%b/%b/%b", c,
                     ifa.Y, ifa.done, ifa.busy, ifa.in_ready, e.y, e.done, e.busy, ifa.en & ~e.busy);
         end
         drive(0, e, idx < 4, 1'b1, idx[1:0], acc);
         if (acc) begin
            if (last >= 0) begin
               n_checks++;
               if (c - last != 6) begin
                  n_fail++;
                  $display("FAIL each_code_spacing: got %0d cycles want 6", c - last);
               end
            end
            last = c;
            idx++;
         end
      end
      n_checks++;
      if (idx != 4) begin
         n_fail++;
         $display("FAIL each_code_count: accepts=%0d want 4", idx);
      end
   endtask

   task automatic test_ignored_input();
      exp_t e;
      bit   acc;
      int   nacc  = 0;
      int   first = 0;
      for (int c = 0; c < 14; c++) begin
         pop(0, e);
         n_checks++;
         if ({ifa.Y, ifa.done, ifa.busy, ifa.in_ready} !== {e.y, e.done, e.busy, ifa.en & ~e.busy}) begin
            n_fail++;
            $display("FAIL ignored c%0d: Y/done/busy/rdy=%b/%b/%b/%b want %b/%b/%b/%b", c,
                     ifa.Y, ifa.done, ifa.busy, ifa.in_ready, e.y, e.done, e.busy, ifa.en & ~e.busy);
         end
         drive(0, e, nacc < 2, 1'b1, (nacc == 0) ? 2'b11 : 2'b00, acc);
         if (acc) begin
            if (nacc == 1) begin
               n_checks++;
               if (c - first != 6) begin
                  n_fail++;
                  $display("FAIL ignored_second_accept: after %0d cycles want 6", c - first);
               end
            end
            first = c;
            nacc++;
         end
      end
   endtask

   task automatic test_abort();
      exp_t e;
      bit   acc;
      int   nacc = 0;
      for (int c = 0; c < 16; c++) begin
         pop(0, e);
         n_checks++;
         if ({ifa.Y, ifa.done, ifa.busy, ifa.in_ready} !== {e.y, e.done, e.busy, ifa.en & ~e.busy}) begin
            n_fail++;
            $display("FAIL abort c%0d: Y/done/busy/rdy=%b/%b/%b/%b want %b/%b/%b/%b", c,
                     ifa.Y, ifa.done, ifa.busy, ifa.in_ready, e.y, e.done, e.busy, ifa.en & ~e.busy);
         end
         drive(0, e, nacc < 2, !(c >= 2 && c < 7), 2'b01, acc);
         if (acc) begin
            if (nacc == 1) begin
               n_checks++;
               if (c != 7) begin
                  n_fail++;
                  $display("FAIL abort_reaccept: cycle %0d want 7", c);
               end
            end
            nacc++;
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      bit   acc;
      int   idx  = 0;
      int   last = -1;
      for (int c = 0; c < 16; c++) begin
         pop(1, e);
         n_checks++;
         if ({ifb.Y, ifb.done, ifb.busy, ifb.in_ready} !== {e.y, e.done, e.busy, ifb.en & ~e.busy}) begin
            n_fail++;
            $display("FAIL b2b c%0d: Y/done/busy/rdy=%b/%b/%b/%b want %b/%b/%b/%b", c,
                     ifb.Y, ifb.done, ifb.busy, ifb.in_ready, e.y, e.done, e.busy, ifb.en & ~e.busy);
         end
         drive(1, e, c < 14, 1'b1, idx[1:0], acc);
         if (acc) begin
            if (last >= 0) begin
               n_checks++;
               if (c - last != 2) begin
                  n_fail++;
                  $display("FAIL b2b_period: got %0d cycles want 2", c - last);
               end
            end
            last = c;
            idx++;
         end
      end
      n_checks++;
      if (idx != 7) begin
         n_fail++;
         $display("FAIL b2b_count: accepts=%0d want 7", idx);
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      bit   acc;
      @(negedge clk);
      drive(0, '0, 1'b1, 1'b1, 2'b10, acc);
      for (int c = 0; c < 2; c++) begin
         pop(0, e);
         n_checks++;
         if ({ifa.Y, ifa.done, ifa.busy} !== {e.y, e.done, e.busy} || e.y != 4'b0100) begin
            n_fail++;
            $display("FAIL async_pre c%0d: Y/done/busy=%b/%b/%b want 0100/0/1", c,
                     ifa.Y, ifa.done, ifa.busy);
         end
         drive(0, e, 1'b0, 1'b1, 2'b00, acc);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ifa.Y, ifa.done, ifa.busy, ifa.in_ready} !== 7'b0000_000) begin
         n_fail++;
         $display("FAIL async_reset: Y/done/busy/rdy=%b/%b/%b/%b want 0000/0/0/0",
                  ifa.Y, ifa.done, ifa.busy, ifa.in_ready);
      end
      q_a.delete();
      q_b.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         pop(0, e);
         n_checks++;
         if ({ifa.Y, ifa.done, ifa.busy, ifa.in_ready} !== {e.y, e.done, e.busy, ifa.en & ~e.busy}) begin
            n_fail++;
            $display("FAIL async_post c%0d: Y/done/busy/rdy=%b/%b/%b/%b want %b/%b/%b/%b", c,
                     ifa.Y, ifa.done, ifa.busy, ifa.in_ready, e.y, e.done, e.busy, ifa.en & ~e.busy);
         end
         drive(0, e, 1'b0, 1'b1, 2'b00, acc);
      end
   endtask

   task automatic test_random();
      exp_t       e;
      bit         acc;
      logic       v;
      logic       en;
      logic [1:0] a;
      for (int c = 0; c < 300; c++) begin
         pop(0, e);
         n_checks++;
         if ({ifa.Y, ifa.done, ifa.busy, ifa.in_ready} !== {e.y, e.done, e.busy, ifa.en & ~e.busy}) begin
            n_fail++;
            $display("FAIL random c%0d: Y/done/busy/rdy=%b/%b/%b/%b want %b/%b/%b/%b", c,
                     ifa.Y, ifa.done, ifa.busy, ifa.in_ready, e.y, e.done, e.busy, ifa.en & ~e.busy);
         end
         n_checks++;
         if (!$onehot0(ifa.Y) || (ifa.done && ifa.Y != 4'b0000) || (ifa.in_ready && ifa.busy)) begin
            n_fail++;
            $display("FAIL invariant c%0d: Y=%b done=%b busy=%b rdy=%b", c,
                     ifa.Y, ifa.done, ifa.busy, ifa.in_ready);
         end
         v  = 1'($urandom_range(0, 1));
         en = ($urandom_range(0, 3) != 0);
         a  = 2'($urandom_range(0, 3));
         drive(0, e, v, en, a, acc);
      end
   endtask

   initial begin
      rst_n        = 1'b1;
      ifa.en       = 1'b1;
      ifa.in_valid = 1'b1;
      ifa.A        = 2'b10;
      ifb.en       = 1'b1;
      ifb.in_valid = 1'b0;
      ifb.A        = 2'b00;
      #1 rst_n = 1'b0;
      test_reset();
      test_each_code();
      test_ignored_input();
      test_abort();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
